sd_cmd_controller: RTL and testbench

//  Host-side SD CMD-line transaction controller. Sits between the host register/command

---
 rtl/sd_cmd_pkg.sv | 24 ++
 rtl/sd_cmd_controller_if.sv | 39 +++
 rtl/sd_cmd_controller.sv | 119 +++++++++++
 tb/tb_sd_cmd_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line transaction controller.
package sd_cmd_pkg;

    localparam int CMD_W  = 40;
    localparam int RESP_W = 136;

    localparam logic START_BIT    = 1'b0;
    localparam logic TRANSMIT_BIT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_ACK,
        WAIT_RESP,
        ACK,
        DONE
    } state_t;

    function automatic logic [CMD_W-1:0] build_frame(input logic [5:0]  index,
                                                     input logic [31:0] argument);
        return {START_BIT, TRANSMIT_BIT, index, argument};
    endfunction

endpackage

// File: rtl/sd_cmd_controller_if.sv
// Host/PHY signal bundle for sd_cmd_controller; dbg_state exposes the FSM state.
// Handshake: strobe_out stays high until ack_in; ack_out stays high until strobe_in drops.
interface sd_cmd_controller_if;
    import sd_cmd_pkg::*;

    logic              new_command;
    logic [31:0]       cmd_argument;
    logic [5:0]        cmd_index;
    logic              TIMEOUT_ENABLE;
    logic              TIMEOUT;
    logic              serial_ready;
    logic              ack_in;
    logic              strobe_in;
    logic [RESP_W-1:0] cmd_in;
    logic              idle_out;
    logic              strobe_out;
    logic              ack_out;
    logic [CMD_W-1:0]  cmd_out;
    logic [RESP_W-1:0] response;
    logic              command_complete;
    logic              timeout_error;
    logic              index_error;
    state_t            dbg_state;

    modport master (
        input  new_command, cmd_argument, cmd_index, TIMEOUT_ENABLE, TIMEOUT,
               serial_ready, ack_in, strobe_in, cmd_in,
        output idle_out, strobe_out, ack_out, cmd_out, response,
               command_complete, timeout_error, index_error, dbg_state
    );

    modport slave (
        output new_command, cmd_argument, cmd_index, TIMEOUT_ENABLE, TIMEOUT,
               serial_ready, ack_in, strobe_in, cmd_in,
        input  idle_out, strobe_out, ack_out, cmd_out, response,
               command_complete, timeout_error, index_error, dbg_state
    );

endinterface

// File: rtl/sd_cmd_controller.sv
// SD CMD-line transaction controller: issues a 40-bit frame, collects the response.
// Define CMD_INDEX_CHECK_EN to compare the response index against the issued index.
module sd_cmd_controller
    import sd_cmd_pkg::*;
(
    input logic                 clock,
    input logic                 reset,
    sd_cmd_controller_if.master bus
);

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              complete_q, complete_d;
    logic              timeout_err_q, timeout_err_d;
    logic              timeout_hit;
`ifdef CMD_INDEX_CHECK_EN
    logic              index_err_q, index_err_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            resp_q        <= '0;
            complete_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            resp_q        <= resp_d;
            complete_q    <= complete_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef CMD_INDEX_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) index_err_q <= 1'b0;
        else       index_err_q <= index_err_d;
    end
`endif

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        resp_d        = resp_q;
        complete_d    = 1'b0;
        timeout_err_d = timeout_err_q;
`ifdef CMD_INDEX_CHECK_EN
        index_err_d   = index_err_q;
`endif
        timeout_hit   = bus.TIMEOUT_ENABLE && bus.TIMEOUT;

        case (state_q)
            IDLE: begin
                if (bus.new_command) begin
                    cmd_d         = build_frame(bus.cmd_index, bus.cmd_argument);
                    timeout_err_d = 1'b0;
`ifdef CMD_INDEX_CHECK_EN
                    index_err_d   = 1'b0;
`endif
                    state_d       = SETUP;
                end
            end
            SETUP: begin
                if (bus.serial_ready) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    complete_d    = 1'b1;
                    state_d       = DONE;
                end else if (bus.ack_in) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving with TIMEOUT is still a valid response.
                if (bus.strobe_in) begin
                    resp_d  = bus.cmd_in;
`ifdef CMD_INDEX_CHECK_EN
                    index_err_d = (bus.cmd_in[45:40] != cmd_q[37:32]);
`endif
                    state_d = ACK;
                end else if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    complete_d    = 1'b1;
                    state_d       = DONE;
                end
            end
            ACK: begin
                if (!bus.strobe_in) begin
                    complete_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (!bus.new_command) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.idle_out         = (state_q == IDLE);
    assign bus.strobe_out       = (state_q == WAIT_ACK);
    assign bus.ack_out          = (state_q == ACK);
    assign bus.cmd_out          = cmd_q;
    assign bus.response         = resp_q;
    assign bus.command_complete = complete_q;
    assign bus.timeout_error    = timeout_err_q;
    assign bus.dbg_state        = state_q;
`ifdef CMD_INDEX_CHECK_EN
    assign bus.index_error      = index_err_q;
`else
    assign bus.index_error      = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Directed table-driven bench for sd_cmd_controller plus a bounded hand-written transaction.
module tb_sd_cmd_controller;
    import sd_cmd_pkg::*;

`ifdef CMD_INDEX_CHECK_EN
    localparam logic IDX_CHK = 1'b1;
`else
    localparam logic IDX_CHK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    sd_cmd_controller_if bus ();

    sd_cmd_controller dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              nc;
        logic [5:0]        idx;
        logic [31:0]       arg;
        logic              to_en;
        logic              to;
        logic              sr;
        logic              ack;
        logic              stb;
        logic [RESP_W-1:0] cin;
        logic              e_idle;
        logic              e_strobe;
        logic              e_ack;
        logic              e_cc;
        logic              e_to;
        logic              e_ie;
        logic [CMD_W-1:0]  e_cmd;
        logic [RESP_W-1:0] e_resp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [RESP_W-1:0] mk_resp(input logic [5:0] i, input logic [31:0] a);
        return {88'h0, 2'b00, i, a, 8'h01};
    endfunction

    task automatic add(input logic r, nc, input logic [5:0] idx, input logic [31:0] arg,
                       input logic to_en, to, sr, ack, stb, input logic [RESP_W-1:0] cin,
                       input logic e_idle, e_strobe, e_ack, e_cc, e_to, e_ie,
                       input logic [CMD_W-1:0] e_cmd, input logic [RESP_W-1:0] e_resp);
        vec_t v;
        v.rst = r; v.nc = nc; v.idx = idx; v.arg = arg;
        v.to_en = to_en; v.to = to; v.sr = sr; v.ack = ack; v.stb = stb; v.cin = cin;
        v.e_idle = e_idle; v.e_strobe = e_strobe; v.e_ack = e_ack; v.e_cc = e_cc;
        v.e_to = e_to; v.e_ie = e_ie; v.e_cmd = e_cmd; v.e_resp = e_resp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [RESP_W-1:0] act, input logic [RESP_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.strobe_out;
            1:       return bus.ack_out;
            default: return bus.command_complete;
        endcase
    endfunction

    // Waits at most 20 cycles for the selected output to reach val.
    task automatic wait_for(input int which, input logic val, input string name);
        int n;
        n = 0;
        while (sig(which) !== val && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, {135'h0, sig(which)}, {135'h0, val});
    endtask

    initial begin
        logic [RESP_W-1:0] r1, r2, r3, r4, r5, rb, z;
        logic [CMD_W-1:0]  c1, c3, c4, c5, c6;
        n_cmp  = 0;
        n_fail = 0;
        z  = '0;
        r1 = mk_resp(6'd11, 32'h3BA692AF);
        r2 = mk_resp(6'd12, 32'hFA74CD23);
        r3 = mk_resp(6'd5,  32'hAAAA5555);
        r4 = mk_resp(6'd7,  32'h11223344);
        r5 = mk_resp(6'd1,  32'hCAFEF00D);
        rb = mk_resp(6'd9,  32'h13579BDF);
        c1 = 40'h4CFA74CD23;
        c3 = 40'h45DEADBEEF;
        c4 = 40'h4300000000;
        c5 = 40'h4711223344;
        c6 = 40'h4100000000;

        //  rst nc idx    arg            ten to sr ack stb cin   idle stb ack cc to ie       cmd resp
        add(1, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 0, 0,       '0, z);
        add(1, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 0, 0,       '0, z);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 0, 0,       '0, z);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c1, z);
        add(0, 1, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c1, z);
        add(0, 0, 6'd0,  32'h0,         0, 0, 1, 0, 0, z,    0, 1, 0, 0, 0, 0,       c1, z);
        add(0, 0, 6'd0,  32'h0,         0, 0, 1, 0, 0, z,    0, 1, 0, 0, 0, 0,       c1, z);
        add(0, 0, 6'd0,  32'h0,         0, 0, 1, 1, 0, z,    0, 0, 0, 0, 0, 0,       c1, z);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, r3,   0, 0, 0, 0, 0, 0,       c1, z);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 1, r1,   0, 0, 1, 0, 0, IDX_CHK, c1, r1);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 1, z,    0, 0, 1, 0, 0, IDX_CHK, c1, r1);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    0, 0, 0, 1, 0, IDX_CHK, c1, r1);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 0, IDX_CHK, c1, r1);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c1, r1);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 1, 0, 0, z,    0, 1, 0, 0, 0, 0,       c1, r1);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 1, 1, 0, z,    0, 0, 0, 0, 0, 0,       c1, r1);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 1, 0, 1, r2,   0, 0, 1, 0, 0, 0,       c1, r2);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 1, 0, 0, z,    0, 0, 0, 1, 0, 0,       c1, r2);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 1, 0, 0, z,    0, 0, 0, 0, 0, 0,       c1, r2);
        add(0, 1, 6'd12, 32'hFA74CD23,  0, 0, 1, 0, 0, z,    0, 0, 0, 0, 0, 0,       c1, r2);
        add(0, 0, 6'd0,  32'h0,         0, 0, 1, 0, 0, z,    1, 0, 0, 0, 0, 0,       c1, r2);
        add(0, 1, 6'd5,  32'hDEADBEEF,  1, 0, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c3, r2);
        add(0, 0, 6'd0,  32'h0,         1, 0, 1, 0, 0, z,    0, 1, 0, 0, 0, 0,       c3, r2);
        add(0, 0, 6'd0,  32'h0,         1, 0, 0, 1, 0, z,    0, 0, 0, 0, 0, 0,       c3, r2);
        add(0, 0, 6'd0,  32'h0,         0, 1, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c3, r2);
        add(0, 0, 6'd0,  32'h0,         1, 1, 0, 0, 0, r3,   0, 0, 0, 1, 1, 0,       c3, r2);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 1, 0,       c3, r2);
        add(0, 1, 6'd3,  32'h0,         0, 0, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c4, r2);
        add(0, 0, 6'd0,  32'h0,         0, 0, 1, 0, 0, z,    0, 1, 0, 0, 0, 0,       c4, r2);
        add(0, 0, 6'd0,  32'h0,         1, 1, 0, 0, 0, z,    0, 0, 0, 1, 1, 0,       c4, r2);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 1, 0,       c4, r2);
        add(0, 1, 6'd7,  32'h11223344,  0, 0, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c5, r2);
        add(0, 0, 6'd0,  32'h0,         0, 0, 1, 0, 0, z,    0, 1, 0, 0, 0, 0,       c5, r2);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 1, 0, z,    0, 0, 0, 0, 0, 0,       c5, r2);
        add(0, 0, 6'd0,  32'h0,         1, 1, 0, 0, 1, r4,   0, 0, 1, 0, 0, 0,       c5, r4);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    0, 0, 0, 1, 0, 0,       c5, r4);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 0, 0,       c5, r4);
        add(0, 1, 6'd1,  32'h0,         0, 0, 0, 0, 0, z,    0, 0, 0, 0, 0, 0,       c6, r4);
        add(0, 0, 6'd0,  32'h0,         0, 0, 1, 0, 0, z,    0, 1, 0, 0, 0, 0,       c6, r4);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 1, 0, z,    0, 0, 0, 0, 0, 0,       c6, r4);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 1, r5,   0, 0, 1, 0, 0, 0,       c6, r5);
        add(1, 0, 6'd0,  32'h0,         0, 0, 0, 0, 1, z,    1, 0, 0, 0, 0, 0,       '0, z);
        add(0, 0, 6'd0,  32'h0,         0, 0, 0, 0, 0, z,    1, 0, 0, 0, 0, 0,       '0, z);

        rst = 1'b1;
        bus.new_command = 0; bus.cmd_index = '0; bus.cmd_argument = '0;
        bus.TIMEOUT_ENABLE = 0; bus.TIMEOUT = 0; bus.serial_ready = 0;
        bus.ack_in = 0; bus.strobe_in = 0; bus.cmd_in = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst                = vecs[i].rst;
            bus.new_command    = vecs[i].nc;
            bus.cmd_index      = vecs[i].idx;
            bus.cmd_argument   = vecs[i].arg;
            bus.TIMEOUT_ENABLE = vecs[i].to_en;
            bus.TIMEOUT        = vecs[i].to;
            bus.serial_ready   = vecs[i].sr;
            bus.ack_in         = vecs[i].ack;
            bus.strobe_in      = vecs[i].stb;
            bus.cmd_in         = vecs[i].cin;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_idle", i),   {135'h0, bus.idle_out},         {135'h0, vecs[i].e_idle});
            chk($sformatf("row%0d_strobe", i), {135'h0, bus.strobe_out},       {135'h0, vecs[i].e_strobe});
            chk($sformatf("row%0d_ack", i),    {135'h0, bus.ack_out},          {135'h0, vecs[i].e_ack});
            chk($sformatf("row%0d_cc", i),     {135'h0, bus.command_complete}, {135'h0, vecs[i].e_cc});
            chk($sformatf("row%0d_tmo", i),    {135'h0, bus.timeout_error},    {135'h0, vecs[i].e_to});
            chk($sformatf("row%0d_idx", i),    {135'h0, bus.index_error},      {135'h0, vecs[i].e_ie});
            chk($sformatf("row%0d_cmd", i),    {96'h0, bus.cmd_out},           {96'h0, vecs[i].e_cmd});
            chk($sformatf("row%0d_resp", i),   bus.response,                   vecs[i].e_resp);
        end

        // Full transaction with a mismatching response index, driven by handshake.
        @(negedge clk);
        bus.new_command = 1; bus.cmd_index = 6'd2; bus.cmd_argument = 32'h13579BDF;
        bus.serial_ready = 1;
        wait_for(0, 1'b1, "hs_strobe_rise");
        chk("hs_cmd", {96'h0, bus.cmd_out}, {96'h0, 40'h4213579BDF});
        @(negedge clk);
        bus.new_command = 0; bus.ack_in = 1;
        wait_for(0, 1'b0, "hs_strobe_fall");
        @(negedge clk);
        bus.ack_in = 0; bus.strobe_in = 1; bus.cmd_in = rb;
        wait_for(1, 1'b1, "hs_ack_rise");
        chk("hs_resp", bus.response, rb);
        chk("hs_index_err", {135'h0, bus.index_error}, {135'h0, IDX_CHK});
        @(negedge clk);
        bus.strobe_in = 0;
        wait_for(2, 1'b1, "hs_complete");
        chk("hs_ack_low", {135'h0, bus.ack_out}, 136'h0);
        @(posedge clk);
        #1;
        chk("hs_complete_pulse", {135'h0, bus.command_complete}, 136'h0);
        chk("hs_back_idle", {135'h0, bus.idle_out}, 136'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
